// File: rtl/fifo_stream_reader.sv
// Read-side companion for push/pop FIFOs: drains a first-word-fall-through read port
// into a registered valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int width     = 8,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [width-1:0]     fifo_rdata,
  output logic                 fifo_pop,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [width-1:0]     down_data,
  output logic [cnt_width-1:0] xfer_count,
  output logic [1:0]           buf_level
);

  localparam logic [1:0] LVL_EMPTY = 2'd0;
  localparam logic [1:0] LVL_ONE   = 2'd1;
  localparam logic [1:0] LVL_FULL  = 2'd2;

  logic [1:0]           level_q, level_d;
  logic [width-1:0]     entry0_q, entry0_d;
  logic [width-1:0]     entry1_q, entry1_d;
  logic [cnt_width-1:0] xfer_q, xfer_d;
  logic                 fill, drain;

  // Pop never looks at down_ready; the second entry absorbs the one-cycle skid.
  assign fifo_pop   = ~rst & ~fifo_empty & (level_q != LVL_FULL);
  assign down_valid = (level_q != LVL_EMPTY);
  assign down_data  = entry0_q;
  assign xfer_count = xfer_q;
  assign buf_level  = level_q;

  assign fill  = fifo_pop;
  assign drain = down_valid & down_ready;

  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    level_d  = level_q + {1'b0, fill} - {1'b0, drain};
    xfer_d   = xfer_q + {{(cnt_width-1){1'b0}}, drain};
    case (level_q)
      LVL_EMPTY: if (fill) entry0_d = fifo_rdata;
      LVL_ONE: begin
        if (fill && !drain)     entry1_d = fifo_rdata;
        else if (fill && drain) entry0_d = fifo_rdata;
      end
      default:   if (drain) entry0_d = entry1_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= LVL_EMPTY;
      xfer_q  <= '0;
    end else begin
      level_q <= level_d;
      xfer_q  <= xfer_d;
    end
  end

  // Data storage carries no reset; validity comes solely from level_q.
  always_ff @(posedge clk) begin
    entry0_q <= entry0_d;
    entry1_q <= entry1_d;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomized checks of fifo_stream_reader against a queue-based source FIFO
// and an in-order scoreboard of popped words.
module tb_fifo_stream_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_pop;
  logic        down_valid;
  logic        down_ready;
  logic [7:0]  down_data;
  logic [15:0] xfer_count;
  logic [1:0]  buf_level;

  logic        pop4, valid4;
  logic [7:0]  data4;
  logic [3:0]  xfer4;
  logic [1:0]  lvl4;

  int asserts = 0;
  int fails   = 0;
  logic [7:0] src[$];
  logic [7:0] scb[$];
  bit gate = 1'b0;

  fifo_stream_reader #(.width(8), .cnt_width(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_pop(fifo_pop), .down_valid(down_valid), .down_ready(down_ready),
    .down_data(down_data), .xfer_count(xfer_count), .buf_level(buf_level));

  fifo_stream_reader #(.width(8), .cnt_width(4)) dut4 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_pop(pop4), .down_valid(valid4), .down_ready(down_ready),
    .down_data(data4), .xfer_count(xfer4), .buf_level(lvl4));

  always #5 clk = ~clk;

  task automatic update_src();
    fifo_empty = gate || (src.size() == 0);
    fifo_rdata = (src.size() != 0) ? src[0] : 8'h00;
  endtask

  // Advance one cycle: pop the source model if the DUT popped before the edge.
  task automatic tick();
    logic p;
    p = fifo_pop;
    @(posedge clk);
    #1;
    if (p) begin
      scb.push_back(src[0]);
      void'(src.pop_front());
    end
    update_src();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gate = 1'b0;
    src.delete();
    scb.delete();
    down_ready = 1'b1;
    update_src();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      asserts++;
      if (fifo_pop !== 1'b0 || down_valid !== 1'b0 || xfer_count !== 16'd0 || buf_level !== 2'd0) begin
        fails++;
        $display("FAIL reset_idle cyc%0d: pop=%b valid=%b xfer=%0d lvl=%0d, expected 0 0 0 0",
                 i, fifo_pop, down_valid, xfer_count, buf_level);
      end
      tick();
    end
  endtask

  task automatic test_basic();
    logic [4:0] ep, ev;
    ep = 5'b00111;
    ev = 5'b01110;
    down_ready = 1'b1;
    src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33);
    update_src();
    #1;
    for (int i = 0; i < 5; i++) begin
      asserts++;
      if (fifo_pop !== ep[i] || down_valid !== ev[i]) begin
        fails++;
        $display("FAIL basic_ctl cyc%0d: pop=%b valid=%b, expected %b %b", i, fifo_pop, down_valid, ep[i], ev[i]);
      end
      if (ev[i]) begin
        asserts++;
        if (down_data !== 8'(8'h11 * i)) begin
          fails++;
          $display("FAIL basic_data cyc%0d: got %0h expected %0h", i, down_data, 8'(8'h11 * i));
        end
      end
      tick();
    end
    asserts++;
    if (xfer_count !== 16'd3 || buf_level !== 2'd0) begin
      fails++;
      $display("FAIL basic_end: xfer=%0d lvl=%0d, expected 3 0", xfer_count, buf_level);
    end
  endtask

  task automatic test_backpressure();
    int pops;
    pops = 0;
    down_ready = 1'b0;
    for (int i = 0; i < 5; i++) src.push_back(8'hA0 + 8'(i));
    update_src();
    #1;
    for (int i = 0; i < 6; i++) begin
      pops += int'(fifo_pop);
      if (i >= 1) begin
        asserts++;
        if (down_valid !== 1'b1 || down_data !== 8'hA0) begin
          fails++;
          $display("FAIL bp_hold cyc%0d: valid=%b data=%0h, expected 1 a0", i, down_valid, down_data);
        end
      end
      tick();
    end
    asserts++;
    if (pops != 2 || buf_level !== 2'd2 || fifo_pop !== 1'b0) begin
      fails++;
      $display("FAIL bp_stall: pops=%0d lvl=%0d pop=%b, expected 2 2 0", pops, buf_level, fifo_pop);
    end
    down_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      asserts++;
      if (down_valid !== 1'b1 || down_data !== 8'hA0 + 8'(i)) begin
        fails++;
        $display("FAIL bp_resume cyc%0d: valid=%b data=%0h, expected 1 %0h", i, down_valid, down_data, 8'hA0 + 8'(i));
      end
      tick();
    end
    asserts++;
    if (buf_level !== 2'd0 || xfer_count !== 16'd8) begin
      fails++;
      $display("FAIL bp_end: lvl=%0d xfer=%0d, expected 0 8", buf_level, xfer_count);
    end
  endtask

  task automatic test_reset_mid();
    down_ready = 1'b0;
    src.push_back(8'hB0); src.push_back(8'hB1); src.push_back(8'hB2);
    update_src();
    #1;
    for (int i = 0; i < 3; i++) tick();
    asserts++;
    if (buf_level !== 2'd2) begin
      fails++;
      $display("FAIL rmid_fill: lvl=%0d expected 2", buf_level);
    end
    rst = 1'b1;
    #1;
    asserts++;
    if (down_valid !== 1'b0 || buf_level !== 2'd0 || fifo_pop !== 1'b0 || xfer_count !== 16'd0) begin
      fails++;
      $display("FAIL rmid_async: valid=%b lvl=%0d pop=%b xfer=%0d, expected 0 0 0 0",
               down_valid, buf_level, fifo_pop, xfer_count);
    end
    @(negedge clk);
    rst = 1'b0;
    scb.delete();
    down_ready = 1'b1;
    #1;
    tick();
    asserts++;
    if (down_valid !== 1'b1 || down_data !== 8'hB2) begin
      fails++;
      $display("FAIL rmid_after: valid=%b data=%0h, expected 1 b2", down_valid, down_data);
    end
    tick();
    asserts++;
    if (buf_level !== 2'd0 || xfer_count !== 16'd1) begin
      fails++;
      $display("FAIL rmid_end: lvl=%0d xfer=%0d, expected 0 1", buf_level, xfer_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) src.push_back(8'(i));
    update_src();
    #1;
    for (int i = 0; i < 20; i++) tick();
    asserts++;
    if (xfer4 !== 4'd1 || xfer_count !== 16'd17 || buf_level !== 2'd0) begin
      fails++;
      $display("FAIL wrap: xfer4=%0d xfer=%0d lvl=%0d, expected 1 17 0", xfer4, xfer_count, buf_level);
    end
  endtask

  task automatic test_random();
    int got;
    bit stall_prev;
    logic [7:0] held;
    logic [7:0] exp;
    got = 0;
    stall_prev = 1'b0;
    held = 8'h00;
    do_reset();
    for (int i = 0; i < 1000; i++) src.push_back(8'($urandom));
    for (int c = 0; c < 30000 && got < 1000; c++) begin
      gate = ($urandom_range(0, 9) < 3);
      down_ready = ($urandom_range(0, 9) < 6);
      update_src();
      #1;
      asserts++;
      if (fifo_pop && (fifo_empty || buf_level == 2'd2)) begin
        fails++;
        $display("FAIL rnd_pop cyc%0d: pop=1 with empty=%b lvl=%0d", c, fifo_empty, buf_level);
      end
      if (stall_prev) begin
        asserts++;
        if (down_valid !== 1'b1 || down_data !== held) begin
          fails++;
          $display("FAIL rnd_stable cyc%0d: valid=%b data=%0h, expected 1 %0h", c, down_valid, down_data, held);
        end
      end
      if (down_valid && down_ready) begin
        exp = (scb.size() != 0) ? scb.pop_front() : 8'hxx;
        asserts++;
        if (down_data !== exp) begin
          fails++;
          $display("FAIL rnd_order word%0d: got %0h expected %0h", got, down_data, exp);
        end
        got++;
      end
      stall_prev = down_valid && !down_ready;
      held = down_data;
      tick();
    end
    asserts++;
    if (got != 1000) begin
      fails++;
      $display("FAIL rnd_count: got %0d words expected 1000", got);
    end
  endtask

  initial begin
    rst = 1'b1;
    down_ready = 1'b1;
    update_src();
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
